// File: rtl/function_unit.sv
// function_unit: 16-bit ALU with single-cycle ops and a 16-iteration shift-add multiplier.
module function_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic [3:0]  FS,
  input  logic        start,
  output logic [15:0] D,
  output logic        V,
  output logic        C,
  output logic        N,
  output logic        Z,
  output logic        busy,
  output logic        done
);
  typedef enum logic {IDLE, MUL} state_t;
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d, fs_q, fs_d;
  logic [31:0] acc_q, acc_d;
  logic [15:0] mcand_q, mcand_d, mplier_q, mplier_d, d_q, d_d;
  logic        v_q, v_d, c_q, c_d, z_q, z_d, done_q, done_d;
  logic [15:0] b_op, res;
  logic [16:0] sum, acc_hi;
  logic        cin, v_r, c_r, is_mul, go, fin;

  always_comb begin
    b_op = FS == 4'h1 ? 16'h0000 : FS == 4'h3 ? ~B : FS == 4'h4 ? 16'hFFFF : B;
    cin  = FS == 4'h1 || FS == 4'h3;
    sum  = {1'b0, A} + {1'b0, b_op} + {16'b0, cin};
    res  = '0;
    c_r  = 1'b0;
    v_r  = 1'b0;
    case (FS)
      4'h0: res = A;
      4'h1, 4'h2, 4'h3, 4'h4: begin
        res = sum[15:0];
        c_r = sum[16];
        v_r = (A[15] == b_op[15]) && (sum[15] != A[15]);
      end
      4'h5: res = A & B;
      4'h6: res = A | B;
      4'h7: res = A ^ B;
      4'h8: res = ~A;
      4'h9: res = B;
      4'hA: begin
        res = {1'b0, B[15:1]};
        c_r = B[0];
      end
      4'hB: begin
        res = {B[14:0], 1'b0};
        c_r = B[15];
      end
      default: res = '0;
    endcase
  end

  // One multiply step: add the gated multiplicand into the top half, then shift right.
  always_comb begin
    is_mul   = FS == 4'hC || FS == 4'hD;
    go       = state_q == IDLE && start;
    fin      = state_q == MUL && cnt_q == 4'hF;
    acc_hi   = {1'b0, acc_q[31:16]} + {1'b0, mplier_q[0] ? mcand_q : 16'h0000};
    state_d  = state_q;
    cnt_d    = cnt_q;
    fs_d     = fs_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    d_d      = d_q;
    v_d      = v_q;
    c_d      = c_q;
    z_d      = z_q;
    done_d   = 1'b0;
    if (go) begin
      fs_d = FS;
      if (is_mul) begin
        state_d  = MUL;
        cnt_d    = '0;
        acc_d    = '0;
        mcand_d  = A;
        mplier_d = B;
      end else begin
        d_d    = res;
        c_d    = c_r;
        v_d    = v_r;
        z_d    = res == 16'h0000;
        done_d = 1'b1;
      end
    end else if (state_q == MUL) begin
      acc_d    = {acc_hi, acc_q[15:1]};
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 4'd1;
      if (fin) begin
        state_d = IDLE;
        d_d     = fs_q == 4'hC ? acc_d[15:0] : acc_d[31:16];
        v_d     = fs_q == 4'hC && |acc_d[31:16];
        c_d     = 1'b0;
        z_d     = d_d == 16'h0000;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      fs_q     <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      d_q      <= '0;
      v_q      <= 1'b0;
      c_q      <= 1'b0;
      z_q      <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      fs_q     <= fs_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      d_q      <= d_d;
      v_q      <= v_d;
      c_q      <= c_d;
      z_q      <= z_d;
      done_q   <= done_d;
    end
  end

  assign D    = d_q;
  assign V    = v_q;
  assign C    = c_q;
  assign N    = d_q[15];
  assign Z    = z_q;
  assign busy = state_q == MUL;
  assign done = done_q;
endmodule
